// File: rtl/pixel_stream_feeder_if.sv
// Pixel stream bundle between the camera front end and the row-chain feeder.
// Master side is the camera/testbench, slave side is the feeder.
interface pixel_stream_feeder_if #(
  parameter int DATA_WIDTH_8  = 8,
  parameter int DATA_WIDTH_12 = 12
);
  logic                     i_pixel_valid;
  logic [DATA_WIDTH_8-1:0]  i_pixel;
  logic                     i_sof;
  logic                     i_stall;
  logic                     o_pixel_ready;
  logic                     o_wen;
  logic [DATA_WIDTH_12-1:0] o_fifo_in;
  logic [DATA_WIDTH_12-1:0] o_reduction_sum;
  logic [DATA_WIDTH_12-1:0] o_col;
  logic [DATA_WIDTH_12-1:0] o_row;
  logic                     o_end_of_line;
  logic                     o_end_of_frame;
  logic                     o_frame_error;

  modport master (
    output i_pixel_valid, i_pixel, i_sof, i_stall,
    input  o_pixel_ready, o_wen, o_fifo_in, o_reduction_sum, o_col, o_row,
           o_end_of_line, o_end_of_frame, o_frame_error
  );

  modport slave (
    input  i_pixel_valid, i_pixel, i_sof, i_stall,
    output o_pixel_ready, o_wen, o_fifo_in, o_reduction_sum, o_col, o_row,
           o_end_of_line, o_end_of_frame, o_frame_error
  );
endinterface

// File: rtl/pixel_stream_feeder.sv
// Front end of the integral-image row chain: accepts camera pixels, tracks
// column/row, emits write enable, zero-extended pixel, per-line running sum
// and line/frame markers, all registered with one cycle of latency.
// Optional build macro ROW_SUM_SATURATE_EN: running sum clamps at full scale
// instead of wrapping.
//
// state  | meaning
// IDLE   | waiting for a pixel qualified by i_sof; other pixels dropped
// ACTIVE | inside a frame; every accepted pixel is emitted
module pixel_stream_feeder #(
  parameter int DATA_WIDTH_8        = 8,
  parameter int DATA_WIDTH_12       = 12,
  parameter int FRAME_CAMERA_WIDTH  = 10,
  parameter int FRAME_CAMERA_HEIGHT = 10
) (
  input logic                 clk_os,
  input logic                 reset_os_n,
  pixel_stream_feeder_if.slave px
);

  localparam int PAD_W = DATA_WIDTH_12 - DATA_WIDTH_8;
  localparam logic [DATA_WIDTH_12-1:0] COL_LAST = DATA_WIDTH_12'(FRAME_CAMERA_WIDTH - 1);
  localparam logic [DATA_WIDTH_12-1:0] ROW_LAST = DATA_WIDTH_12'(FRAME_CAMERA_HEIGHT - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                   state_q, state_d;
  logic [DATA_WIDTH_12-1:0] col_q, col_d;
  logic [DATA_WIDTH_12-1:0] row_q, row_d;
  logic [DATA_WIDTH_12-1:0] sum_q, sum_d;
  logic [DATA_WIDTH_12-1:0] fifo_q, fifo_d;
  logic [DATA_WIDTH_12-1:0] ocol_q, ocol_d;
  logic [DATA_WIDTH_12-1:0] orow_q, orow_d;
  logic                     wen_q, wen_d;
  logic                     eol_q, eol_d;
  logic                     eof_q, eof_d;
  logic                     err_q, err_d;

  logic                     accept;
  logic                     emit;
  logic                     is_eol;
  logic                     is_eof;
  logic [DATA_WIDTH_12-1:0] ec;
  logic [DATA_WIDTH_12-1:0] er;
  logic [DATA_WIDTH_12-1:0] pix_ext;
  logic [DATA_WIDTH_12:0]   sum_base;
  logic [DATA_WIDTH_12:0]   sum_wide;

  assign px.o_pixel_ready = !px.i_stall;
  assign accept           = px.i_pixel_valid && !px.i_stall;
  assign pix_ext          = {{PAD_W{1'b0}}, px.i_pixel};

  // State and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge clk_os or negedge reset_os_n) begin
    if (!reset_os_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      sum_q   <= '0;
      fifo_q  <= '0;
      ocol_q  <= '0;
      orow_q  <= '0;
      wen_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      sum_q   <= sum_d;
      fifo_q  <= fifo_d;
      ocol_q  <= ocol_d;
      orow_q  <= orow_d;
      wen_q   <= wen_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      err_q   <= err_d;
    end
  end

  // Next-state: decide whether to emit, at which position, and advance counters.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    sum_d    = sum_q;
    fifo_d   = fifo_q;
    ocol_d   = ocol_q;
    orow_d   = orow_q;
    wen_d    = 1'b0;
    eol_d    = 1'b0;
    eof_d    = 1'b0;
    err_d    = 1'b0;
    emit     = 1'b0;
    ec       = col_q;
    er       = row_q;
    is_eol   = 1'b0;
    is_eof   = 1'b0;
    sum_base = '0;
    sum_wide = '0;

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (px.i_sof) begin
            emit = 1'b1;
            ec   = '0;
            er   = '0;
          end
        end
        ACTIVE: begin
          emit = 1'b1;
          if (px.i_sof) begin
            // A frame start inside a frame restarts the frame at (0,0).
            ec    = '0;
            er    = '0;
            err_d = (col_q != '0) || (row_q != '0);
          end
        end
        default: emit = 1'b0;
      endcase
    end

    if (emit) begin
      is_eol   = (ec == COL_LAST);
      is_eof   = is_eol && (er == ROW_LAST);
      sum_base = (ec == '0) ? '0 : {1'b0, sum_q};
      sum_wide = sum_base + {1'b0, pix_ext};
`ifdef ROW_SUM_SATURATE_EN
      sum_d    = sum_wide[DATA_WIDTH_12] ? '1 : sum_wide[DATA_WIDTH_12-1:0];
`else
      sum_d    = sum_wide[DATA_WIDTH_12-1:0];
`endif
      fifo_d   = pix_ext;
      ocol_d   = ec;
      orow_d   = er;
      wen_d    = 1'b1;
      eol_d    = is_eol;
      eof_d    = is_eof;
      col_d    = is_eol ? '0 : ec + 1'b1;
      row_d    = is_eol ? (is_eof ? '0 : er + 1'b1) : er;
      state_d  = is_eof ? IDLE : ACTIVE;
    end
  end

  assign px.o_wen           = wen_q;
  assign px.o_fifo_in       = fifo_q;
  assign px.o_reduction_sum = sum_q;
  assign px.o_col           = ocol_q;
  assign px.o_row           = orow_q;
  assign px.o_end_of_line   = eol_q;
  assign px.o_end_of_frame  = eof_q;
  assign px.o_frame_error   = err_q;

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Directed bench for pixel_stream_feeder: a 10x10 instance for framing,
// stall, resync and reset cases, and a 20-wide instance for sum overflow.
module tb_pixel_stream_feeder;

  logic clk_os = 1'b0;
  logic reset_os_n;
  int   vectors = 0;
  int   miscompares = 0;
  logic rdy_seen;
  int   expsum;

  always #5 clk_os = ~clk_os;

  pixel_stream_feeder_if ifa ();
  pixel_stream_feeder_if ifw ();

  pixel_stream_feeder #(
    .DATA_WIDTH_8(8), .DATA_WIDTH_12(12),
    .FRAME_CAMERA_WIDTH(10), .FRAME_CAMERA_HEIGHT(10)
  ) u_dut (
    .clk_os(clk_os), .reset_os_n(reset_os_n), .px(ifa)
  );

  pixel_stream_feeder #(
    .DATA_WIDTH_8(8), .DATA_WIDTH_12(12),
    .FRAME_CAMERA_WIDTH(20), .FRAME_CAMERA_HEIGHT(10)
  ) u_dut_w20 (
    .clk_os(clk_os), .reset_os_n(reset_os_n), .px(ifw)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [7:0] p, input logic s, input logic st);
    @(negedge clk_os);
    ifa.i_pixel_valid = v;
    ifa.i_pixel       = p;
    ifa.i_sof         = s;
    ifa.i_stall       = st;
    #1 rdy_seen = ifa.o_pixel_ready;
    @(posedge clk_os);
    #1;
  endtask

  task automatic drive_w(input logic v, input logic [7:0] p, input logic s);
    @(negedge clk_os);
    ifw.i_pixel_valid = v;
    ifw.i_pixel       = p;
    ifw.i_sof         = s;
    ifw.i_stall       = 1'b0;
    @(posedge clk_os);
    #1;
  endtask

  task automatic chk_emit(input string t, input int col, input int row, input int sum,
                          input logic eol, input logic eof, input logic err);
    chk({t, ".wen"}, ifa.o_wen, 1);
    chk({t, ".col"}, ifa.o_col, col);
    chk({t, ".row"}, ifa.o_row, row);
    chk({t, ".sum"}, ifa.o_reduction_sum, sum);
    chk({t, ".eol"}, ifa.o_end_of_line, eol);
    chk({t, ".eof"}, ifa.o_end_of_frame, eof);
    chk({t, ".err"}, ifa.o_frame_error, err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.i_pixel_valid = 0; ifa.i_pixel = 0; ifa.i_sof = 0; ifa.i_stall = 0;
    ifw.i_pixel_valid = 0; ifw.i_pixel = 0; ifw.i_sof = 0; ifw.i_stall = 0;
    reset_os_n = 1'b0;
    repeat (2) @(posedge clk_os);
    #1;
    chk("rst.wen", ifa.o_wen, 0);
    chk("rst.fifo", ifa.o_fifo_in, 0);
    chk("rst.sum", ifa.o_reduction_sum, 0);
    chk("rst.col", ifa.o_col, 0);
    chk("rst.row", ifa.o_row, 0);
    chk("rst.eol", ifa.o_end_of_line, 0);
    chk("rst.eof", ifa.o_end_of_frame, 0);
    chk("rst.err", ifa.o_frame_error, 0);
    @(negedge clk_os);
    reset_os_n = 1'b1;

    // Pixels without a frame start are dropped while idle.
    for (int i = 0; i < 5; i++) begin
      drive_a(1, 8'(i + 40), 0, 0);
      chk($sformatf("idle%0d.rdy", i), rdy_seen, 1);
      chk($sformatf("idle%0d.wen", i), ifa.o_wen, 0);
      chk($sformatf("idle%0d.col", i), ifa.o_col, 0);
    end

    // Full 10x10 frame, pixel = col + 1.
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        drive_a(1, 8'(c + 1), (r == 0 && c == 0), 0);
        chk_emit($sformatf("f1(%0d,%0d)", r, c), c, r, (c + 1) * (c + 2) / 2,
                 c == 9, (r == 9 && c == 9), 0);
        if (c == 0) chk($sformatf("f1(%0d,0).fifo", r), ifa.o_fifo_in, 1);
      end
    drive_a(1, 8'd77, 0, 0);
    chk("post_frame.wen", ifa.o_wen, 0);
    chk("post_frame.eof_drop", ifa.o_end_of_frame, 0);

    // Second frame: stall after col 4.
    for (int c = 0; c < 5; c++) begin
      drive_a(1, 8'(c + 1), c == 0, 0);
      chk_emit($sformatf("f2(0,%0d)", c), c, 0, (c + 1) * (c + 2) / 2, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      drive_a(1, 8'd6, 0, 1);
      chk($sformatf("stall%0d.rdy", i), rdy_seen, 0);
      chk($sformatf("stall%0d.wen", i), ifa.o_wen, 0);
      chk($sformatf("stall%0d.col_hold", i), ifa.o_col, 4);
      chk($sformatf("stall%0d.sum_hold", i), ifa.o_reduction_sum, 15);
    end
    drive_a(1, 8'd6, 0, 0);
    chk_emit("after_stall", 5, 0, 21, 0, 0, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 10; c++) begin
        if ((r == 0 && c < 6) || (r == 3 && c > 5)) continue;
        drive_a(1, 8'(c + 1), 0, 0);
        chk_emit($sformatf("f2(%0d,%0d)", r, c), c, r, (c + 1) * (c + 2) / 2, c == 9, 0, 0);
      end

    // Frame start at (3,6): resync to (0,0).
    drive_a(1, 8'd9, 1, 0);
    chk_emit("resync", 0, 0, 9, 0, 0, 1);
    chk("resync.fifo", ifa.o_fifo_in, 9);
    expsum = 9;
    for (int c = 1; c < 10; c++) begin
      drive_a(1, 8'(c + 1), 0, 0);
      expsum += c + 1;
      chk_emit($sformatf("f3(0,%0d)", c), c, 0, expsum, c == 9, 0, 0);
    end
    for (int r = 1; r < 3; r++)
      for (int c = 0; c < 10; c++) begin
        if (r == 2 && c > 3) continue;
        drive_a(1, 8'(c + 1), 0, 0);
        chk_emit($sformatf("f3(%0d,%0d)", r, c), c, r, (c + 1) * (c + 2) / 2, c == 9, 0, 0);
      end
    drive_a(0, 8'd0, 0, 0);
    chk("gap.wen", ifa.o_wen, 0);
    chk("gap.col_hold", ifa.o_col, 3);

    // Reset in mid-frame clears outputs at once.
    @(negedge clk_os);
    reset_os_n = 1'b0;
    #1;
    chk("mrst.wen", ifa.o_wen, 0);
    chk("mrst.fifo", ifa.o_fifo_in, 0);
    chk("mrst.sum", ifa.o_reduction_sum, 0);
    chk("mrst.col", ifa.o_col, 0);
    chk("mrst.row", ifa.o_row, 0);
    @(negedge clk_os);
    reset_os_n = 1'b1;
    drive_a(1, 8'd4, 0, 0);
    chk("mrst.nosof.wen", ifa.o_wen, 0);
    drive_a(1, 8'd5, 1, 0);
    chk_emit("mrst.sof", 0, 0, 5, 0, 0, 0);
    drive_a(1, 8'd6, 0, 0);
    chk_emit("mrst.next", 1, 0, 11, 0, 0, 0);
    drive_a(0, 8'd0, 0, 0);

    // 20-wide line of 255s: sum overflow behaviour.
    for (int c = 0; c < 18; c++) begin
      drive_w(1, 8'd255, c == 0);
      if (c == 15) chk("w20.c15.sum", ifw.o_reduction_sum, 4080);
`ifdef ROW_SUM_SATURATE_EN
      if (c == 16) chk("w20.c16.sum", ifw.o_reduction_sum, 4095);
      if (c == 17) chk("w20.c17.sum", ifw.o_reduction_sum, 4095);
`else
      if (c == 16) chk("w20.c16.sum", ifw.o_reduction_sum, 239);
      if (c == 17) chk("w20.c17.sum", ifw.o_reduction_sum, 494);
`endif
      if (c == 17) chk("w20.c17.col", ifw.o_col, 17);
    end
    drive_w(0, 8'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
